pool_frame_collector: RTL and testbench
=======================================

# pool_frame_collector

Receive-side endpoint for the pixel pipeline's max-pool output stream (`valid_out_pool` / `out_pool`). It captures one frame of pooled pixels and tags each with its linear frame address. Captured pixels are buffered in a small FIFO and handed to a downstream memory writer over a ready/valid handshake. The block signals end-of-frame and any data loss, giving the hardware an on-chip equivalent of the bench's result-file writer.

## Interface
Parameters:
- `IMG_W`, 109, pooled frame width in pixels
- `IMG_H`, 109, pooled frame height in pixels
- `ADDR_W`, 16, width of the address output; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- `DEPTH`, 16, FIFO entries; power of two, >= 2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `start`  in  1  one-cycle pulse that arms capture of a frame
- `valid_in`  in  1  pooled pixel strobe from the pipeline; no backpressure exists upstream
- `data_in`  in  8  pooled pixel value
- `out_valid`  out  1  FIFO head entry valid
- `out_ready`  in  1  downstream accepts the head entry
- `out_data`  out  8  head pixel value
- `out_addr`  out  ADDR_W  head pixel linear address, row*IMG_W+col
- `out_last`  out  1  head entry is the last pixel of the frame (address IMG_W*IMG_H-1)
- `busy`  out  1  state is not IDLE
- `frame_done`  out  1  one-cycle pulse when the frame is fully drained
- `overflow`  out  1  sticky flag: a sample was dropped because the FIFO was full
- `excess`  out  1  sticky flag: `valid_in` arrived after the frame was complete

## Operation
- States:
  - IDLE: `valid_in` is ignored. `start` clears the column/row counters, `overflow` and `excess`, then moves to ACTIVE.
  - ACTIVE: each `valid_in` cycle pushes {data_in, addr, last} and advances `col`. At IMG_W-1, `col` wraps to 0 and `row` increments. Once IMG_W*IMG_H pixels have been pushed, the block moves to DRAIN.
  - DRAIN: `valid_in` is not pushed; it sets `excess`. When the FIFO is empty, the block moves to DONE.
  - DONE: `frame_done`=1 for exactly this one cycle, then the block returns to IDLE.
- `start` outside IDLE is ignored.
- Pixel count semantics: a pixel counts as part of the frame even if it was dropped. The address counter advances on every accepted `valid_in` in ACTIVE, so dropped pixels leave address gaps and the frame still terminates.
- Push rule: push succeeds if count<DEPTH, or if a pop occurs in the same cycle. Otherwise the sample is dropped and `overflow` is set to 1.
- Pop: occurs when `out_valid && out_ready`.
- Head outputs: `out_data`, `out_addr` and `out_last` are the head entry of the register-array FIFO. Their values are held stable while `out_valid=1 && out_ready=0`.
- FIFO pointers are log2(DEPTH)+1 bits wide; full/empty are decided by comparing the MSBs.
- Reset mid-frame: all state returns to IDLE, the FIFO is emptied, and all outputs are 0. Nothing resumes afterwards.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `frame_done`=0, `overflow`=0, `excess`=0.
- `start` at edge N: `busy`=1 from after edge N. `valid_in` at edge N+1 is the first one captured.
- Push at edge N into an empty FIFO: `out_valid`=1 after edge N, with that entry on the head. There is no combinational path from `data_in` to any output.
- Sustained throughput: one push and one pop per cycle. With `out_ready` held at 1, the FIFO never holds more than 1 entry.
- `frame_done` pulses the cycle after the final pop empties the FIFO. `busy` drops after that pulse.
- `overflow` and `excess` assert the cycle after the offending edge and hold until the next `start` or reset.

## Test plan
- Basic frame, IMG_W=4, IMG_H=3, `out_ready`=1: `start`, then 12 back-to-back `valid_in` with data 0..11 -> 12 pops with out_addr 0..11 equal to data; `out_last` only at addr 11; one `frame_done` pulse; `overflow`=`excess`=0.
- Backpressure overflow, DEPTH=4, `out_ready`=0: 6 pushes -> `overflow`=1 and the FIFO holds addr 0..3. Release `out_ready` and push 6 more -> the remaining pops carry addresses 6..11 with no repeats, and the frame completes.
- Full-and-pop same cycle, DEPTH=4: FIFO full, then `valid_in`=1 with `out_ready`=1 -> push accepted and `overflow` stays 0.
- Excess data: after the 12th pixel, with `out_ready`=0, pulse `valid_in` -> `excess`=1 and no extra entry. Drain -> exactly 12 pops.
- Ignored inputs: `valid_in` in IDLE produces no `out_valid`; a second `start` mid-frame leaves the address sequence unchanged.
- Default parameters: 11881 pixels streamed at random gaps with random `out_ready` -> addresses 0..11880 in order, `out_last` at 11880, exactly one `frame_done`; assert `rst_n` mid-frame -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/pool_frame_collector.sv
// rtl/pool_frame_collector.sv - captures one pooled frame, tags pixels with linear address, buffers them in a FIFO
module pool_frame_collector #(
  parameter int IMG_W  = 109,
  parameter int IMG_H  = 109,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              valid_in,
  input  logic [7:0]        data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              excess
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H + 1) : 1;
  localparam int EW = ADDR_W + 9;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] addr;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [EW-1:0]     head;
  logic              empty, full, pop, take, push, frame_last;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign take       = (state == S_ACTIVE) && valid_in;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = take && (!full || pop);
  assign frame_last = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  // Head is gated by out_valid so every output reads 0 while the FIFO is empty.
  assign head       = mem[rd_ptr[PW-1:0]];
  assign out_data   = out_valid ? head[EW-1 -: 8] : 8'd0;
  assign out_addr   = out_valid ? head[ADDR_W:1] : '0;
  assign out_last   = out_valid ? head[0] : 1'b0;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_ACTIVE;
      S_ACTIVE: if (take && frame_last) state_nxt = S_DRAIN;
      S_DRAIN:  if (empty) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      addr     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      excess   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        col      <= '0;
        row      <= '0;
        addr     <= '0;
        overflow <= 1'b0;
        excess   <= 1'b0;
      end else if (take) begin
        // Dropped pixels still advance the address so the frame terminates.
        addr <= addr + ADDR_W'(1);
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (!push) overflow <= 1'b1;
      end
      if (state == S_DRAIN && valid_in) excess <= 1'b1;
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {data_in, addr, frame_last};
  end

endmodule

// File: tb/tb_pool_frame_collector.sv
// tb/tb_pool_frame_collector.sv - scoreboard bench for pool_frame_collector (small and default-size instances)
module tb_pool_frame_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic        a_start = 0, a_valid_in = 0, a_out_ready = 0;
  logic [7:0]  a_data_in = 0;
  logic        a_out_valid, a_out_last, a_busy, a_frame_done, a_overflow, a_excess;
  logic [7:0]  a_out_data;
  logic [15:0] a_out_addr;

  logic        b_start = 0, b_valid_in = 0, b_out_ready = 0;
  logic [7:0]  b_data_in = 0;
  logic        b_out_valid, b_out_last, b_busy, b_frame_done, b_overflow, b_excess;
  logic [7:0]  b_out_data;
  logic [15:0] b_out_addr;

  pool_frame_collector #(.IMG_W(4), .IMG_H(3), .ADDR_W(16), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .valid_in(a_valid_in), .data_in(a_data_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_addr(a_out_addr),
    .out_last(a_out_last), .busy(a_busy), .frame_done(a_frame_done), .overflow(a_overflow),
    .excess(a_excess));

  pool_frame_collector dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .valid_in(b_valid_in), .data_in(b_data_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_addr(b_out_addr),
    .out_last(b_out_last), .busy(b_busy), .frame_done(b_frame_done), .overflow(b_overflow),
    .excess(b_excess));

  int n_checks = 0;
  int n_fail = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  logic [24:0] qa[$];
  logic [24:0] qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input int addr, input int data);
    qa.push_back({16'(addr), 8'(data), (addr == 11)});
  endtask

  task automatic wait_idle_a(input int max);
    int k = 0;
    while (a_busy && k < max) begin
      tick();
      k++;
    end
    check("a_idle_timeout", 32'(a_busy), 32'd0);
  endtask

  // Monitor: every handshake on either output port pops and checks the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) check("a_unexpected_pop", 32'({a_out_addr, a_out_data, a_out_last}), 32'h1ffffff);
        else check("a_pop", 32'({a_out_addr, a_out_data, a_out_last}), 32'(qa.pop_front()));
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) check("b_unexpected_pop", 32'({b_out_addr, b_out_data, b_out_last}), 32'h1ffffff);
        else check("b_pop", 32'({b_out_addr, b_out_data, b_out_last}), 32'(qb.pop_front()));
      end
      if (a_frame_done) a_done_cnt++;
      if (b_frame_done) b_done_cnt++;
    end
  end

  initial begin
    int i;
    int k;
    #2;
    check("a_reset_outputs", 32'({a_out_valid, a_out_data, a_out_addr, a_out_last, a_busy,
          a_frame_done, a_overflow, a_excess}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic frame with continuous ready
    a_out_ready = 1;
    a_start = 1; tick(); a_start = 0;
    check("a_busy_after_start", 32'(a_busy), 32'd1);
    for (i = 0; i < 12; i++) begin
      a_valid_in = 1; a_data_in = 8'(i); expect_a(i, i); tick();
    end
    a_valid_in = 0;
    wait_idle_a(50);
    check("basic_done_count", 32'(a_done_cnt), 32'd1);
    check("basic_flags", 32'({a_overflow, a_excess}), 32'd0);
    check("basic_queue_empty", 32'(qa.size()), 32'd0);

    // Backpressure overflow: addrs 4,5 dropped, 6..11 accepted
    a_out_ready = 0;
    a_start = 1; tick(); a_start = 0;
    for (i = 0; i < 6; i++) begin
      a_valid_in = 1; a_data_in = 8'(8'h40 + i);
      if (i < 4) expect_a(i, 8'h40 + i);
      tick();
      if (i == 0) check("first_push_head", 32'({a_out_valid, a_out_addr}), 32'h10000);
    end
    a_valid_in = 0;
    check("overflow_set", 32'(a_overflow), 32'd1);
    check("head_held", 32'({a_out_valid, a_out_addr, a_out_data}), 32'h1000040);
    a_out_ready = 1;
    for (i = 6; i < 12; i++) begin
      a_valid_in = 1; a_data_in = 8'(8'h40 + i); expect_a(i, 8'h40 + i); tick();
    end
    a_valid_in = 0;
    wait_idle_a(50);
    check("overflow_done_count", 32'(a_done_cnt), 32'd2);
    check("overflow_queue_empty", 32'(qa.size()), 32'd0);

    // Full FIFO accepts a push when a pop happens in the same cycle
    a_out_ready = 0;
    a_start = 1; tick(); a_start = 0;
    check("overflow_cleared_by_start", 32'(a_overflow), 32'd0);
    for (i = 0; i < 12; i++) begin
      if (i == 4) a_out_ready = 1;
      a_valid_in = 1; a_data_in = 8'(8'h80 + i); expect_a(i, 8'h80 + i); tick();
      if (i == 4) check("full_pop_push_no_overflow", 32'(a_overflow), 32'd0);
    end
    a_valid_in = 0;
    wait_idle_a(50);
    check("full_pop_overflow_end", 32'(a_overflow), 32'd0);
    check("full_pop_done_count", 32'(a_done_cnt), 32'd3);

    // Excess data after the frame
    a_out_ready = 1;
    a_start = 1; tick(); a_start = 0;
    for (i = 0; i < 12; i++) begin
      a_valid_in = 1; a_data_in = 8'(8'hC0 + i); expect_a(i, 8'hC0 + i); tick();
    end
    a_out_ready = 0; a_valid_in = 1; a_data_in = 8'hEE; tick();
    a_valid_in = 0;
    check("excess_set", 32'(a_excess), 32'd1);
    check("excess_head_last", 32'({a_out_valid, a_out_addr, a_out_last}), 32'h20017);
    a_out_ready = 1;
    wait_idle_a(50);
    check("excess_queue_empty", 32'(qa.size()), 32'd0);
    check("excess_done_count", 32'(a_done_cnt), 32'd4);

    // Ignored inputs: valid_in in IDLE, start mid-frame
    a_out_ready = 1;
    for (i = 0; i < 3; i++) begin
      a_valid_in = 1; a_data_in = 8'hAA; tick();
      check("idle_valid_ignored", 32'({a_out_valid, a_busy}), 32'd0);
    end
    a_start = 1; a_valid_in = 0; tick(); a_start = 0;
    for (i = 0; i < 12; i++) begin
      a_start = (i == 5);
      a_valid_in = 1; a_data_in = 8'(8'h10 + i); expect_a(i, 8'h10 + i); tick();
    end
    a_start = 0; a_valid_in = 0;
    wait_idle_a(50);
    check("restart_ignored_queue_empty", 32'(qa.size()), 32'd0);
    check("restart_done_count", 32'(a_done_cnt), 32'd5);

    // Default-size frame, random gaps and random ready
    b_start = 1; tick(); b_start = 0;
    i = 0;
    while (i < 11881) begin
      b_valid_in = 1'($urandom_range(0, 1));
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (b_valid_in) begin
        b_data_in = 8'(i) ^ 8'h5A;
        qb.push_back({16'(i), 8'(i) ^ 8'h5A, (i == 11880)});
        i++;
      end
      tick();
    end
    b_valid_in = 0; b_out_ready = 1;
    k = 0;
    while (b_busy && k < 200) begin tick(); k++; end
    check("b_idle_timeout", 32'(b_busy), 32'd0);
    check("b_queue_empty", 32'(qb.size()), 32'd0);
    check("b_done_count", 32'(b_done_cnt), 32'd1);
    check("b_flags", 32'({b_overflow, b_excess}), 32'd0);

    // Reset mid-frame
    b_out_ready = 0;
    b_start = 1; tick(); b_start = 0;
    for (i = 0; i < 5; i++) begin
      b_valid_in = 1; b_data_in = 8'hF0; tick();
    end
    b_valid_in = 0;
    check("b_pre_reset_valid", 32'({b_out_valid, b_busy}), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("b_reset_outputs", 32'({b_out_valid, b_out_data, b_out_addr, b_out_last, b_busy,
          b_frame_done, b_overflow, b_excess}), 32'd0);
    tick();
    rst_n = 1'b1;
    b_out_ready = 1;
    tick(); tick(); tick();
    check("b_no_resume", 32'({b_out_valid, b_busy}), 32'd0);
    check("a_queue_final", 32'(qa.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
